// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator command sequencer.
//   Opcode values driven to the ALU.
//   Status codes returned as the first reply byte.
//   The sequencer state encoding.
//   Small decode helpers used by the FSM.
package calc_pkg;

  // ALU opcodes. OP_DIV is also the highest legal opcode byte.
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Reply status codes.
  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BADOP  = 8'h01;
  localparam logic [7:0] ST_ALUERR = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_A    = 3'd1,
    S_GET_B    = 3'd2,
    S_START    = 3'd3,
    S_WAIT_ALU = 3'd4,
    S_TX_STAT  = 3'd5,
    S_TX_HI    = 3'd6,
    S_TX_LO    = 3'd7
  } state_e;

  // An opcode byte is legal only if its upper six bits are clear and
  // it is at most OP_DIV.
  function automatic logic opcode_valid(input logic [7:0] b);
    return (b <= {6'b000000, OP_DIV});
  endfunction

  // True in the three reply-transmit states.
  function automatic logic is_tx_state(input state_e s);
    return (s == S_TX_STAT) || (s == S_TX_HI) || (s == S_TX_LO);
  endfunction

endpackage

// File: rtl/calc_byte_timeout.sv
// calc_byte_timeout: inter-byte timeout counter.
//   clk      in  system clock
//   rst      in  asynchronous active-low reset
//   clr_i    in  restart the count (byte accepted / frame start); wins over en_i
//   en_i     in  count this cycle (receive states only)
//   expire_o out combinational: en_i & !clr_i & count == TIMEOUT_CYC-1
module calc_byte_timeout #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned TO_W        = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Next count: clear has priority; the count parks at LAST so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + TO_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte arriving in the expiry cycle clears the count and suppresses expiry.
  assign expire_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/calc_cmd_seq.sv
// calc_cmd_seq: command sequencer between the byte receiver and the ALU.
// It collects the 3-byte frame {opcode, A, B}, launches one ALU operation,
// and returns the 3-byte reply {status, result[15:8], result[7:0]}.
//   clk, rst                 clock, asynchronous active-low reset
//   rx_data/rx_rdy           received byte and its 1-cycle strobe
//   alu_op/a/b, alu_start    ALU command and 1-cycle launch pulse
//   alu_done/result/err      ALU completion pulse with qualified result
//   tx_data/valid, tx_ready  reply byte handshake (held until accepted)
//   busy                     high outside IDLE
//   frame_err                1-cycle pulse: inter-byte timeout, frame dropped
//   overrun                  1-cycle pulse: byte arrived while not receiving
// All outputs are registered.
module calc_cmd_seq
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned TO_W        = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic [1:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic        alu_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun
);

  state_e      state_q, state_d;
  logic        op_ok_q, op_ok_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  status_q, status_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        alu_start_q, alu_start_d;
  logic        busy_q, busy_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  logic        to_clr_s;
  logic        to_en_s;
  logic        to_expire_s;

  assign to_en_s = (state_q == S_GET_A) || (state_q == S_GET_B);

  calc_byte_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (to_clr_s),
    .en_i     (to_en_s),
    .expire_o (to_expire_s)
  );

  // FSM next state, frame/result capture and event pulses.
  always_comb begin
    state_d     = state_q;
    op_ok_d     = op_ok_q;
    alu_op_d    = alu_op_q;
    a_d         = a_q;
    b_d         = b_q;
    status_d    = status_q;
    result_d    = result_q;
    to_clr_s    = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_rdy) begin
          op_ok_d  = opcode_valid(rx_data);
          alu_op_d = rx_data[1:0];
          to_clr_s = 1'b1;
          state_d  = S_GET_A;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_GET_A: begin
        if (rx_rdy) begin
          a_d      = rx_data;
          to_clr_s = 1'b1;
          state_d  = S_GET_B;
        end else if (to_expire_s) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d  = S_GET_A;
        end
      end
      S_GET_B: begin
        if (rx_rdy) begin
          b_d      = rx_data;
          to_clr_s = 1'b1;
          if (op_ok_q) begin
            state_d = S_START;
          end else begin
            // Illegal opcode: reply immediately without touching the ALU.
            status_d = ST_BADOP;
            result_d = 16'h0000;
            state_d  = S_TX_STAT;
          end
        end else if (to_expire_s) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d  = S_GET_B;
        end
      end
      S_START: begin
        overrun_d = rx_rdy;
        state_d   = S_WAIT_ALU;
      end
      S_WAIT_ALU: begin
        overrun_d = rx_rdy;
        if (alu_done) begin
          status_d = alu_err ? ST_ALUERR : ST_OK;
          result_d = alu_err ? 16'h0000 : alu_result;
          state_d  = S_TX_STAT;
        end else begin
          state_d  = S_WAIT_ALU;
        end
      end
      // In TX states tx_valid is high, so tx_ready alone means "accepted".
      S_TX_STAT: begin
        overrun_d = rx_rdy;
        if (tx_ready) begin
          state_d = S_TX_HI;
        end else begin
          state_d = S_TX_STAT;
        end
      end
      S_TX_HI: begin
        overrun_d = rx_rdy;
        if (tx_ready) begin
          state_d = S_TX_LO;
        end else begin
          state_d = S_TX_HI;
        end
      end
      S_TX_LO: begin
        overrun_d = rx_rdy;
        if (tx_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_TX_LO;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the next state so they line up with it.
  always_comb begin
    alu_start_d = (state_d == S_START);
    busy_d      = (state_d != S_IDLE);
    tx_valid_d  = is_tx_state(state_d);
    case (state_d)
      S_TX_STAT: tx_data_d = status_d;
      S_TX_HI:   tx_data_d = result_d[15:8];
      S_TX_LO:   tx_data_d = result_d[7:0];
      default:   tx_data_d = tx_data_q;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_ok_q     <= 1'b0;
      alu_op_q    <= 2'd0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      status_q    <= 8'h00;
      result_q    <= 16'h0000;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      alu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_ok_q     <= op_ok_d;
      alu_op_q    <= alu_op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      status_q    <= status_d;
      result_q    <= result_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      alu_start_q <= alu_start_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_start = alu_start_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_calc_cmd_seq.sv
// Self-checking bench for calc_cmd_seq with TIMEOUT_CYC=16.
// Inputs are driven 1 time unit after the rising edge. Outputs are compared
// on the falling edge against a transaction-level model: the model tracks
// the byte count, pending launch/wait and a queue of reply bytes.
module tb_calc_cmd_seq;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rdy = 1'b0;
  logic [1:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic        alu_err = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy, frame_err, overrun;

  always #5 clk = ~clk;

  calc_cmd_seq #(.TIMEOUT_CYC(TO), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] reply[$];
  int         nbytes = 0;
  int         idle = 0;
  logic [7:0] m_opc = 8'h00, m_a = 8'h00, m_b = 8'h00;
  logic [1:0] m_op = 2'd0;
  logic       m_start = 1'b0, m_wait = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

  task automatic model_reset();
    reply.delete();
    nbytes = 0; idle = 0;
    m_opc = 8'h00; m_a = 8'h00; m_b = 8'h00; m_op = 2'd0;
    m_start = 1'b0; m_wait = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_step();
    logic ns, nf, no;
    ns = 1'b0; nf = 1'b0; no = 1'b0;
    if (reply.size() != 0) begin
      if (rx_rdy) no = 1'b1;
      if (tx_ready) void'(reply.pop_front());
    end else if (m_start) begin
      if (rx_rdy) no = 1'b1;
      m_wait = 1'b1;
    end else if (m_wait) begin
      if (rx_rdy) no = 1'b1;
      if (alu_done) begin
        m_wait = 1'b0;
        if (alu_err) reply = {8'h02, 8'h00, 8'h00};
        else         reply = {8'h00, alu_result[15:8], alu_result[7:0]};
      end
    end else if (rx_rdy) begin
      idle = 0;
      if (nbytes == 0) begin
        m_opc = rx_data; m_op = rx_data[1:0]; nbytes = 1;
      end else if (nbytes == 1) begin
        m_a = rx_data; nbytes = 2;
      end else begin
        m_b = rx_data; nbytes = 0;
        if (m_opc <= 8'h03) ns = 1'b1;
        else reply = {8'h01, 8'h00, 8'h00};
      end
    end else if (nbytes != 0) begin
      if (idle == TO - 1) begin
        nf = 1'b1; nbytes = 0;
      end else begin
        idle++;
      end
    end
    m_start = ns; m_ferr = nf; m_ovr = no;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // ---------------- per-cycle compare and monitor ----------------
  logic [7:0] got[$];
  int         start_cnt = 0;
  int         ferr_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("busy", 16'(busy), 16'((nbytes != 0) || m_start || m_wait || (reply.size() != 0)));
        check("tx_valid", 16'(tx_valid), 16'(reply.size() != 0));
        if (reply.size() != 0) check("tx_data", 16'(tx_data), 16'(reply[0]));
        check("alu_start", 16'(alu_start), 16'(m_start));
        check("alu_op", 16'(alu_op), 16'(m_op));
        check("alu_a", 16'(alu_a), 16'(m_a));
        check("alu_b", 16'(alu_b), 16'(m_b));
        check("frame_err", 16'(frame_err), 16'(m_ferr));
        check("overrun", 16'(overrun), 16'(m_ovr));
        if (tx_valid && tx_ready) got.push_back(tx_data);
        if (alu_start) start_cnt++;
        if (frame_err) ferr_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_rdy = 1'b1;
    step();
    rx_rdy = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b);
    send_byte(o); send_byte(a); send_byte(b);
  endtask

  // Plays the ALU: waits (bounded) for alu_start, then after 'dly' cycles pulses alu_done.
  task automatic alu_respond(input logic [15:0] res, input logic err, input int dly);
    int i;
    i = 0;
    while (!alu_start && i < 40) begin step(); i++; end
    check("alu_start_seen", 16'(alu_start), 16'h0001);
    repeat (dly) step();
    alu_done = 1'b1; alu_result = res; alu_err = err;
    step();
    alu_done = 1'b0; alu_result = 16'h0000; alu_err = 1'b0;
  endtask

  task automatic expect_reply(input string name, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int i;
    i = 0;
    while (got.size() < 3 && i < 60) begin step(); i++; end
    check({name, "_len"}, 16'(got.size()), 16'd3);
    if (got.size() >= 3) begin
      check({name, "_b0"}, 16'(got[0]), 16'(b0));
      check({name, "_b1"}, 16'(got[1]), 16'(b1));
      check({name, "_b2"}, 16'(got[2]), 16'(b2));
    end
    step();
    got.delete();
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int s0;
    repeat (3) step();
    check("rst_busy", 16'(busy), 16'h0000);
    check("rst_tx_valid", 16'(tx_valid), 16'h0000);
    check("rst_tx_data", 16'(tx_data), 16'h0000);
    check("rst_alu_start", 16'(alu_start), 16'h0000);
    check("rst_alu_ab", {alu_a, alu_b}, 16'h0000);
    rst = 1'b1;
    tx_ready = 1'b1;
    step();

    // Stray alu_done in IDLE must be ignored.
    alu_done = 1'b1; alu_result = 16'h1234;
    step();
    alu_done = 1'b0; alu_result = 16'h0000;
    step();
    check("stray_done_busy", 16'(busy), 16'h0000);
    check("stray_done_txv", 16'(tx_valid), 16'h0000);

    // Add frame: launch exactly one cycle after the third byte.
    send_frame(8'h00, 8'h12, 8'h34);
    check("f1_start", 16'(alu_start), 16'h0001);
    check("f1_ab", {alu_a, alu_b}, 16'h1234);
    check("f1_op", 16'(alu_op), 16'h0000);
    alu_respond(16'h0046, 1'b0, 1);
    check("f1_txv_latency", 16'(tx_valid), 16'h0001);
    expect_reply("f1", 8'h00, 8'h00, 8'h46);

    // Illegal opcode: no launch, status 01.
    s0 = start_cnt;
    send_frame(8'h07, 8'h01, 8'h02);
    check("f2_no_start", 16'(alu_start), 16'h0000);
    check("f2_stat", {8'(tx_valid), tx_data}, 16'h0101);
    expect_reply("f2", 8'h01, 8'h00, 8'h00);
    check("f2_start_cnt", 16'(start_cnt - s0), 16'h0000);

    // ALU error: result forced to zero.
    send_frame(8'h03, 8'h05, 8'h00);
    check("f3_op", 16'(alu_op), 16'h0003);
    alu_respond(16'hFFFF, 1'b1, 2);
    expect_reply("f3", 8'h02, 8'h00, 8'h00);

    // Timeout after two bytes.
    s0 = ferr_cnt;
    send_byte(8'h01);
    send_byte(8'h05);
    repeat (TO - 1) step();
    check("to_not_yet", 16'(frame_err), 16'h0000);
    check("to_busy_before", 16'(busy), 16'h0001);
    step();
    check("to_pulse", 16'(frame_err), 16'h0001);
    check("to_busy_after", 16'(busy), 16'h0000);
    check("to_no_txv", 16'(tx_valid), 16'h0000);
    step();
    check("to_one_pulse", 16'(ferr_cnt - s0), 16'h0001);
    send_frame(8'h02, 8'h03, 8'h04);
    alu_respond(16'h000C, 1'b0, 3);
    expect_reply("f4", 8'h00, 8'h00, 8'h0C);

    // Overrun during WAIT_ALU, then stalled TX_HI.
    send_frame(8'h02, 8'h40, 8'h08);
    step();
    send_byte(8'hAA);
    check("ovr_pulse", 16'(overrun), 16'h0001);
    check("ovr_ab", {alu_a, alu_b}, 16'h4008);
    tx_ready = 1'b0;
    alu_done = 1'b1; alu_result = 16'h0200;
    step();
    alu_done = 1'b0; alu_result = 16'h0000;
    check("f5_stat", {8'(tx_valid), tx_data}, 16'h0100);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("f5_hold", {8'(tx_valid), tx_data}, 16'h0102);
    end
    tx_ready = 1'b1;
    expect_reply("f5", 8'h00, 8'h02, 8'h00);

    // Reset while in TX_HI.
    tx_ready = 1'b0;
    send_frame(8'h00, 8'h01, 8'h01);
    alu_respond(16'h0002, 1'b0, 1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_mid_txv", 16'(tx_valid), 16'h0000);
    check("rst_mid_busy", 16'(busy), 16'h0000);
    check("rst_mid_ab", {alu_a, alu_b}, 16'h0000);
    step();
    step();
    rst = 1'b1;
    tx_ready = 1'b1;
    got.delete();
    step();
    send_frame(8'h00, 8'h02, 8'h03);
    alu_respond(16'h0005, 1'b0, 1);
    expect_reply("f6", 8'h00, 8'h00, 8'h05);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
